// File: rtl/key_expansion.sv
// AES-128 round-key schedule with independent encryption/decryption read pointers.
// Optional status outputs are enabled by defining KEY_EXPANSION_STATUS_EN.
module key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         set_new_key,
    input  logic         start_enc,
    input  logic         ready_enc,
    input  logic         start_dec,
    input  logic         ready_dec,
`ifdef KEY_EXPANSION_STATUS_EN
    output logic         schedule_valid,
    output logic [3:0]   enc_round,
    output logic [3:0]   dec_round,
`endif
    output logic [127:0] key_enc,
    output logic [127:0] key_dec
);

    logic [127:0] rk_r [0:10];
    logic [3:0]   enc_ptr_r;
    logic [3:0]   dec_ptr_r;
    logic         schedule_valid_r;
    logic         ready_enc_q_r;
    logic         ready_dec_q_r;
    logic         enc_step_s;
    logic         dec_step_s;
    logic [127:0] next_key_s;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (aa & {8{b[i]}});
            aa = {aa[6:0], 1'b0} ^ (8'h1b & {8{aa[7]}});
        end
        return p;
    endfunction

    // S-box built from the field inverse (x^254, zero maps to zero) plus the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_round_key(input logic [127:0] w, input logic [7:0] rcon);
        logic [31:0] rot;
        logic [31:0] t;
        logic [31:0] w0n;
        logic [31:0] w1n;
        logic [31:0] w2n;
        logic [31:0] w3n;
        rot = {w[23:0], w[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon, 24'h000000};
        w0n = w[127:96] ^ t;
        w1n = w[95:64]  ^ w0n;
        w2n = w[63:32]  ^ w1n;
        w3n = w[31:0]   ^ w2n;
        return {w0n, w1n, w2n, w3n};
    endfunction

    // Step detection, next-key generation and pointer-selected key reads
    always_comb begin
        enc_step_s = ready_enc & ~ready_enc_q_r;
        dec_step_s = ready_dec & ~ready_dec_q_r;
        next_key_s = next_round_key(rk_r[enc_ptr_r], rcon_of(enc_ptr_r));
        key_enc    = rk_r[enc_ptr_r];
        key_dec    = rk_r[dec_ptr_r];
    end

    // Key storage, pointers and edge-detect history; load overrides both pointer paths
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                rk_r[i] <= 128'h0;
            end
            enc_ptr_r        <= 4'd0;
            dec_ptr_r        <= 4'd0;
            schedule_valid_r <= 1'b0;
            ready_enc_q_r    <= 1'b0;
            ready_dec_q_r    <= 1'b0;
        end else begin
            ready_enc_q_r <= ready_enc;
            ready_dec_q_r <= ready_dec;
            if (set_new_key) begin
                rk_r[0]          <= key_in;
                enc_ptr_r        <= 4'd0;
                dec_ptr_r        <= 4'd0;
                schedule_valid_r <= 1'b0;
            end else begin
                if (start_enc) begin
                    enc_ptr_r <= 4'd0;
                end else if (enc_step_s && (enc_ptr_r < 4'd10)) begin
                    if (!schedule_valid_r) begin
                        rk_r[enc_ptr_r + 4'd1] <= next_key_s;
                        if (enc_ptr_r == 4'd9) begin
                            schedule_valid_r <= 1'b1;
                        end
                    end
                    enc_ptr_r <= enc_ptr_r + 4'd1;
                end
                if (start_dec) begin
                    if (schedule_valid_r) begin
                        dec_ptr_r <= 4'd10;
                    end
                end else if (dec_step_s && (dec_ptr_r != 4'd0)) begin
                    dec_ptr_r <= dec_ptr_r - 4'd1;
                end
            end
        end
    end

`ifdef KEY_EXPANSION_STATUS_EN
    assign schedule_valid = schedule_valid_r;
    assign enc_round      = enc_ptr_r;
    assign dec_round      = dec_ptr_r;
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Directed, table-driven bench for key_expansion using FIPS-197 round keys.
module tb_key_expansion;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         set_new_key;
    logic         start_enc;
    logic         ready_enc;
    logic         start_dec;
    logic         ready_dec;
    logic [127:0] key_enc;
    logic [127:0] key_dec;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KA   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] A1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] A5   = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    localparam logic [127:0] A10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] B10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z1   = 128'h62636363626363636263636362636363;

    typedef enum logic [3:0] {
        OP_LOAD, OP_LOAD_ENC, OP_ENC, OP_DEC, OP_HOLD_ENC,
        OP_START_ENC, OP_START_DEC, OP_ENC_DEC, OP_START_ENC_STEP
    } op_t;

    typedef struct {
        op_t          op;
        int           n;
        logic [127:0] key;
        logic [127:0] exp_enc;
        logic [127:0] exp_dec;
        string        name;
    } vec_t;

    vec_t vecs[$];

    key_expansion dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .set_new_key (set_new_key),
        .start_enc   (start_enc),
        .ready_enc   (ready_enc),
        .start_dec   (start_dec),
        .ready_dec   (ready_dec),
        .key_enc     (key_enc),
        .key_dec     (key_dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(op_t op, int n, logic [127:0] key,
                                logic [127:0] e, logic [127:0] d, string name);
        vec_t v;
        v.op = op; v.n = n; v.key = key; v.exp_enc = e; v.exp_dec = d; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        case (v.op)
            OP_LOAD, OP_LOAD_ENC: begin
                @(negedge clk);
                key_in      = v.key;
                set_new_key = 1'b1;
                ready_enc   = (v.op == OP_LOAD_ENC);
                @(negedge clk);
                set_new_key = 1'b0;
                ready_enc   = 1'b0;
            end
            OP_ENC, OP_DEC, OP_ENC_DEC: begin
                for (int i = 0; i < v.n; i++) begin
                    @(negedge clk);
                    ready_enc = (v.op != OP_DEC);
                    ready_dec = (v.op != OP_ENC);
                    @(negedge clk);
                    ready_enc = 1'b0;
                    ready_dec = 1'b0;
                end
            end
            OP_HOLD_ENC: begin
                @(negedge clk);
                ready_enc = 1'b1;
                repeat (v.n) @(negedge clk);
                ready_enc = 1'b0;
            end
            OP_START_ENC, OP_START_ENC_STEP: begin
                @(negedge clk);
                start_enc = 1'b1;
                ready_enc = (v.op == OP_START_ENC_STEP);
                @(negedge clk);
                start_enc = 1'b0;
                ready_enc = 1'b0;
            end
            OP_START_DEC: begin
                @(negedge clk);
                start_dec = 1'b1;
                @(negedge clk);
                start_dec = 1'b0;
            end
            default: begin
                @(negedge clk);
            end
        endcase
    endtask

    initial begin
        rst = 1'b1; key_in = 128'h0; set_new_key = 1'b0;
        start_enc = 1'b0; ready_enc = 1'b0; start_dec = 1'b0; ready_dec = 1'b0;

        vecs.push_back(mk(OP_LOAD,           1, KA, KA,  KA,  "load_a"));
        vecs.push_back(mk(OP_ENC,            1, KA, A1,  KA,  "enc_1"));
        vecs.push_back(mk(OP_START_DEC,      1, KA, A1,  KA,  "start_dec_invalid"));
        vecs.push_back(mk(OP_ENC,            4, KA, A5,  KA,  "enc_5"));
        vecs.push_back(mk(OP_ENC,            5, KA, A10, KA,  "enc_10"));
        vecs.push_back(mk(OP_ENC,            1, KA, A10, KA,  "enc_11_ignored"));
        vecs.push_back(mk(OP_START_DEC,      1, KA, A10, A10, "start_dec"));
        vecs.push_back(mk(OP_DEC,           10, KA, A10, KA,  "dec_10"));
        vecs.push_back(mk(OP_DEC,            1, KA, A10, KA,  "dec_floor"));
        vecs.push_back(mk(OP_START_DEC,      1, KA, A10, A10, "start_dec_again"));
        vecs.push_back(mk(OP_DEC,            5, KA, A10, A5,  "dec_5"));
        vecs.push_back(mk(OP_START_ENC,      1, KA, KA,  A5,  "start_enc"));
        vecs.push_back(mk(OP_ENC,            5, KA, A5,  A5,  "reenc_5"));
        vecs.push_back(mk(OP_START_ENC,      1, KA, KA,  A5,  "start_enc_2"));
        vecs.push_back(mk(OP_HOLD_ENC,       5, KA, A1,  A5,  "hold_one_step"));
        vecs.push_back(mk(OP_LOAD_ENC,       1, KB, KB,  KB,  "load_beats_step"));
        vecs.push_back(mk(OP_START_DEC,      1, KB, KB,  KB,  "start_dec_invalid_b"));
        vecs.push_back(mk(OP_ENC,            1, KB, B1,  KB,  "enc_b1"));
        vecs.push_back(mk(OP_ENC,            9, KB, B10, KB,  "enc_b10"));
        vecs.push_back(mk(OP_START_DEC,      1, KB, B10, B10, "start_dec_b"));
        vecs.push_back(mk(OP_DEC,            9, KB, B10, B1,  "dec_b9"));
        vecs.push_back(mk(OP_START_ENC,      1, KB, KB,  B1,  "start_enc_b"));
        vecs.push_back(mk(OP_ENC_DEC,        1, KB, B1,  KB,  "enc_dec_same_cycle"));
        vecs.push_back(mk(OP_START_ENC_STEP, 1, KB, KB,  KB,  "start_beats_step"));

        repeat (3) @(negedge clk);
        check("reset_enc", key_enc, 128'h0);
        check("reset_dec", key_dec, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check({vecs[i].name, "_enc"}, key_enc, vecs[i].exp_enc);
            check({vecs[i].name, "_dec"}, key_dec, vecs[i].exp_dec);
        end

        // Reset in the middle of a fresh schedule discards everything
        apply(mk(OP_LOAD, 1, KA, KA, KA, "reload"));
        apply(mk(OP_ENC,  3, KA, KA, KA, "partial"));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_enc", key_enc, 128'h0);
        check("midrst_dec", key_dec, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_enc", key_enc, 128'h0);
        apply(mk(OP_START_DEC, 1, KA, KA, KA, "postrst_start_dec"));
        check("postrst_start_dec", key_dec, 128'h0);
        apply(mk(OP_ENC, 1, KA, KA, KA, "postrst_enc_step"));
        check("postrst_zero_key_step", key_enc, Z1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
